// File: rtl/fetch_prefetch_stage_pkg.sv
// Shared defaults and helpers for the prefetching fetch stage.
package fetch_prefetch_stage_pkg;

    localparam int unsigned WORD_SIZE_DEF = 32;
    localparam int unsigned QDEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_stage_if.sv
// Instruction-memory request/grant + in-order response bus.
interface fetch_prefetch_stage_if
    import fetch_prefetch_stage_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) ();

    logic                 imem_req;
    logic [WORD_SIZE-1:0] imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [WORD_SIZE-1:0] imem_rdata;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    // Memory side
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/fetch_prefetch_stage_fetch_queue.sv
// Prefetch FIFO holding {pc, instr} pairs; head is readable combinationally
// so decode can load it on the same edge it is popped.
module fetch_prefetch_stage_fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i  && (count_q != '0);
    assign push_ok = push_i && (count_q != FULL);

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_stage.sv
// Fetch stage with up to QDEPTH outstanding imem requests and a prefetch
// queue feeding the decode register. Redirects flush the queue and squash
// every response still in flight.
module fetch_prefetch_stage
    import fetch_prefetch_stage_pkg::*;
#(
    parameter int                   WORD_SIZE = WORD_SIZE_DEF,
    parameter int                   QDEPTH    = QDEPTH_DEF,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEF)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        PCSrcE,
    input  logic [WORD_SIZE-1:0]        PCTargetE,
    input  logic                        StallD,
    fetch_prefetch_stage_if.master      imem,
    output logic [WORD_SIZE-1:0]        InstrD,
    output logic [WORD_SIZE-1:0]        PCD,
    output logic [WORD_SIZE-1:0]        PCPlus4D,
    output logic                        ValidD
);

    localparam int CW = cnt_width(QDEPTH);
    localparam int QW = 2 * WORD_SIZE;
    localparam logic [CW:0] QLIM = (CW+1)'(QDEPTH);
    localparam logic [WORD_SIZE-1:0] FOUR = WORD_SIZE'(4);

    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] ret_pc_q, ret_pc_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic [CW-1:0]        disc_cnt_q, disc_cnt_d;
    logic [WORD_SIZE-1:0] instr_q, pcd_q, pcp4_q;
    logic                 valid_q;

    logic [CW-1:0]        q_count;
    logic [QW-1:0]        q_rdata;
    logic                 q_push, q_pop, q_clear;
    logic [CW:0]          credit_sum;
    logic                 grant, rsp;
    logic [WORD_SIZE-1:0] target_aligned;
    logic                 unused_target_lsbs;

    assign target_aligned     = {PCTargetE[WORD_SIZE-1:2], 2'b00};
    assign unused_target_lsbs = ^PCTargetE[1:0];

    // Credit is taken from registered counts only; a same-cycle pop does not help.
    assign credit_sum    = {1'b0, out_cnt_q} + {1'b0, q_count};
    assign imem.imem_req = !rst && !PCSrcE && (credit_sum < QLIM);
    assign imem.imem_addr = pc_q;

    assign grant = imem.imem_req && imem.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp   = imem.imem_rvalid && (out_cnt_q != '0);

    assign q_pop = !PCSrcE && !StallD && (q_count != '0);

    // Next-state for fetch PC, return PC, outstanding and discard counters.
    always_comb begin
        pc_d       = pc_q;
        ret_pc_d   = ret_pc_q;
        out_cnt_d  = out_cnt_q;
        disc_cnt_d = disc_cnt_q;
        q_push     = 1'b0;
        q_clear    = 1'b0;

        case ({grant, rsp})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase

        if (PCSrcE) begin
            pc_d       = target_aligned;
            ret_pc_d   = target_aligned;
            q_clear    = 1'b1;
            // Everything still in flight is stale; this cycle's response too.
            disc_cnt_d = out_cnt_q - CW'(rsp);
        end else begin
            if (grant) pc_d = pc_q + FOUR;
            if (rsp) begin
                if (disc_cnt_q != '0) begin
                    disc_cnt_d = disc_cnt_q - 1'b1;
                end else begin
                    q_push   = 1'b1;
                    ret_pc_d = ret_pc_q + FOUR;
                end
            end
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            ret_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            ret_pc_q   <= ret_pc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
        end
    end

    fetch_prefetch_stage_fetch_queue #(
        .WIDTH (QW),
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .clear_i (q_clear),
        .wdata_i ({ret_pc_q, imem.imem_rdata}),
        .rdata_o (q_rdata),
        .count_o (q_count)
    );

    // Decode register: redirect kills, stall holds, otherwise load the queue head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pcd_q   <= '0;
            pcp4_q  <= '0;
        end else if (PCSrcE) begin
            valid_q <= 1'b0;
        end else if (!StallD) begin
            if (q_count != '0) begin
                valid_q <= 1'b1;
                instr_q <= q_rdata[WORD_SIZE-1:0];
                pcd_q   <= q_rdata[QW-1:WORD_SIZE];
                pcp4_q  <= q_rdata[QW-1:WORD_SIZE] + FOUR;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    // Flags a response arriving with no request outstanding.
    always_ff @(posedge clk) begin
        if (!rst) assert (!(imem.imem_rvalid && (out_cnt_q == '0)));
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

endmodule
